// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    TXQ_IDLE      = 3'd0,
    TXQ_LOAD      = 3'd1,
    TXQ_START     = 3'd2,
    TXQ_WAIT_BUSY = 3'd3,
    TXQ_WAIT_DONE = 3'd4
  } uart_txq_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Push-side and serializer-side signals of the transmit queue.
// master = bus/register side plus serializer, slave = uart_tx_fifo.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   flush;
  logic                   full;
  logic                   empty;
  logic [LW-1:0]          level;
  logic                   overflow;
  logic                   ser_busy;
  logic                   ser_start;
  logic [UART_DATA_W-1:0] ser_data;
  logic                   irq;

  modport master (
    output wr_en, wr_data, flush, ser_busy,
    input  full, empty, level, overflow, ser_start, ser_data, irq
  );

  modport slave (
    input  wr_en, wr_data, flush, ser_busy,
    output full, empty, level, overflow, ser_start, ser_data, irq
  );

endinterface

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO storage: memory array, wrap-bit pointers, occupancy flags
// and a registered read port. Reusable for the receive queue as well.
module sync_fifo_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              tx_clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LW-1:0]     wr_ptr_reg;
  logic [LW-1:0]     rd_ptr_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              do_push;
  logic              do_pop;

  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign level = wr_ptr_reg - rd_ptr_reg;

  // Full is judged on the current pointers, so a same-cycle pop never frees room.
  assign do_push = wr_en && !full && !clear;
  assign do_pop  = rd_en && !empty;

  always_ff @(posedge tx_clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge tx_clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + LW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + LW'(1);
      end
    end
  end

  // The read register latches on every request, even one that a clear overrides.
  always_ff @(posedge tx_clk) begin
    if (!rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit queue feeding the UART serializer via a start/busy handshake.
// Optional low-watermark interrupt enabled by defining UART_TX_FIFO_IRQ_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int LOW_WM = 2
) (
  input logic           tx_clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  localparam logic [2:0] ST_IDLE      = 3'(TXQ_IDLE);
  localparam logic [2:0] ST_LOAD      = 3'(TXQ_LOAD);
  localparam logic [2:0] ST_START     = 3'(TXQ_START);
  localparam logic [2:0] ST_WAIT_BUSY = 3'(TXQ_WAIT_BUSY);
  localparam logic [2:0] ST_WAIT_DONE = 3'(TXQ_WAIT_DONE);

`ifdef UART_TX_FIFO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam logic [LW-1:0] LOW_WM_L = LW'(LOW_WM);

  logic [2:0]             state_reg;
  logic [2:0]             state_next;
  logic                   ser_start_reg;
  logic                   overflow_reg;
  logic                   irq_reg;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LW-1:0]          fifo_level;
  logic [UART_DATA_W-1:0] rd_data;

  assign pop = (state_reg == ST_LOAD);

  sync_fifo_core #(
    .DATA_W (UART_DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .tx_clk  (tx_clk),
    .rst     (rst),
    .clear   (bus.flush),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // A flush in the same cycle as the launch decision would leave LOAD with
  // nothing to read, so launching waits one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (!fifo_empty && !bus.ser_busy && !bus.flush) state_next = ST_LOAD;
      ST_LOAD:      state_next = ST_START;
      ST_START:     state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (bus.ser_busy)  state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!bus.ser_busy) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      ser_start_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      // High exactly while in START: set on the LOAD -> START edge.
      ser_start_reg <= (state_reg == ST_LOAD);
      if (bus.flush) begin
        overflow_reg <= 1'b0;
      end else if (bus.wr_en && fifo_full) begin
        overflow_reg <= 1'b1;
      end
      irq_reg <= IRQ_ON && (fifo_level <= LOW_WM_L) && !bus.flush;
    end
  end

  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.level     = fifo_level;
  assign bus.overflow  = overflow_reg;
  assign bus.ser_start = ser_start_reg;
  assign bus.ser_data  = rd_data;
  assign bus.irq       = irq_reg;

endmodule
